// File: rtl/sound_rom_arbiter.sv
`default_nettype none
// ============================================================================
// sound_rom_arbiter : shares one 16-bit sound ROM read port between the V35
// CPU (with a one-word fetch cache) and four GA20 sample channels.
// Revision 1.0
// ============================================================================
module sound_rom_arbiter #(
  parameter int AW            = 20,
  parameter int CPU_BURST_MAX = 4
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            cpu_req,
  input  logic [AW-1:0]   cpu_addr,
  output logic            cpu_ack,
  output logic [15:0]     cpu_data,
  input  logic [3:0]      smp_req,
  input  logic [4*AW-1:0] smp_addr,
  output logic [3:0]      smp_ack,
  output logic [7:0]      smp_data,
  output logic            mem_rd,
  output logic [AW-1:0]   mem_addr,
  input  logic            mem_ready,
  input  logic [15:0]     mem_data,
  output logic            busy
);

  localparam int            SW         = $clog2(CPU_BURST_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(CPU_BURST_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            mem_rd_q, mem_rd_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic [15:0]     cpu_data_q, cpu_data_d;
  logic [3:0]      smp_ack_q, smp_ack_d;
  logic [7:0]      smp_data_q, smp_data_d;
  logic            busy_q, busy_d;
  logic            gnt_cpu_q, gnt_cpu_d;
  logic [1:0]      gnt_ch_q, gnt_ch_d;
  logic            byte_sel_q, byte_sel_d;
  logic            cache_valid_q, cache_valid_d;
  logic [AW-2:0]   cache_tag_q, cache_tag_d;
  logic [15:0]     cache_data_q, cache_data_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]   streak_q, streak_d;

  logic            hit;
  logic            cpu_win;
  logic            smp_any;
  logic [1:0]      smp_sel;
  logic [AW-1:0]   smp_sel_addr;

  // Offsets are scanned high to low so the nearest requester above rr_ptr wins.
  always_comb begin
    smp_sel = rr_ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (smp_req[rr_ptr_q + 2'(i)]) smp_sel = rr_ptr_q + 2'(i);
    end
  end

  assign smp_any      = |smp_req;
  assign smp_sel_addr = smp_addr[smp_sel*AW +: AW];
  assign hit          = cpu_req && cache_valid_q && (cpu_addr[AW-1:1] == cache_tag_q);
  assign cpu_win      = cpu_req && ((streak_q < STREAK_MAX) || !smp_any);

  always_comb begin
    state_d       = state_q;
    mem_rd_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    cpu_ack_d     = 1'b0;
    cpu_data_d    = cpu_data_q;
    smp_ack_d     = 4'b0000;
    smp_data_d    = smp_data_q;
    gnt_cpu_d     = gnt_cpu_q;
    gnt_ch_d      = gnt_ch_q;
    byte_sel_d    = byte_sel_q;
    cache_valid_d = cache_valid_q;
    cache_tag_d   = cache_tag_q;
    cache_data_d  = cache_data_q;
    rr_ptr_d      = rr_ptr_q;
    streak_d      = streak_q;

    case (state_q)
      IDLE: begin
        if (hit) begin
          cpu_ack_d  = 1'b1;
          cpu_data_d = cache_data_q;
          state_d    = DONE;
        end else if (cpu_win) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = {cpu_addr[AW-1:1], 1'b0};
          gnt_cpu_d  = 1'b1;
          byte_sel_d = cpu_addr[0];
          state_d    = WAIT;
        end else if (smp_any) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = {smp_sel_addr[AW-1:1], 1'b0};
          gnt_cpu_d  = 1'b0;
          gnt_ch_d   = smp_sel;
          byte_sel_d = smp_sel_addr[0];
          state_d    = WAIT;
        end
      end
      WAIT: begin
        // Ack and bookkeeping are registered on the capture edge so the
        // acks appear in the DONE cycle.
        if (mem_ready) begin
          state_d = DONE;
          if (gnt_cpu_q) begin
            cpu_ack_d     = 1'b1;
            cpu_data_d    = mem_data;
            cache_valid_d = 1'b1;
            cache_tag_d   = mem_addr_q[AW-1:1];
            cache_data_d  = mem_data;
            if (streak_q < STREAK_MAX) streak_d = streak_q + SW'(1);
          end else begin
            smp_ack_d  = 4'b0001 << gnt_ch_q;
            smp_data_d = byte_sel_q ? mem_data[15:8] : mem_data[7:0];
            rr_ptr_d   = gnt_ch_q + 2'd1;
            streak_d   = '0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (flush) cache_valid_d = 1'b0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= '0;
      cpu_ack_q     <= 1'b0;
      cpu_data_q    <= '0;
      smp_ack_q     <= '0;
      smp_data_q    <= '0;
      busy_q        <= 1'b0;
      gnt_cpu_q     <= 1'b0;
      gnt_ch_q      <= '0;
      byte_sel_q    <= 1'b0;
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
      rr_ptr_q      <= '0;
      streak_q      <= '0;
    end else begin
      state_q       <= state_d;
      mem_rd_q      <= mem_rd_d;
      mem_addr_q    <= mem_addr_d;
      cpu_ack_q     <= cpu_ack_d;
      cpu_data_q    <= cpu_data_d;
      smp_ack_q     <= smp_ack_d;
      smp_data_q    <= smp_data_d;
      busy_q        <= busy_d;
      gnt_cpu_q     <= gnt_cpu_d;
      gnt_ch_q      <= gnt_ch_d;
      byte_sel_q    <= byte_sel_d;
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_data_q  <= cache_data_d;
      rr_ptr_q      <= rr_ptr_d;
      streak_q      <= streak_d;
    end
  end

  assign cpu_ack  = cpu_ack_q;
  assign cpu_data = cpu_data_q;
  assign smp_ack  = smp_ack_q;
  assign smp_data = smp_data_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire
